// File: rtl/verificador_xor_if.sv
// Bus between the stimulus side of the XOR lab bench and the response monitor.
// The master drives stimulus and the observed response; the slave (the monitor) returns its statistics.
interface verificador_xor_if #(
  parameter int ANCHO = 2
) ();
  logic             inicio;
  logic [ANCHO-1:0] estimulo;
  logic             estimulo_valido;
  logic             respuesta;
  logic             ocupado;
  logic             completo;
  logic [15:0]      contador_vectores;
  logic [7:0]       contador_errores;
  logic             hubo_error;
  logic [ANCHO-1:0] primer_error;

  modport master (
    output inicio, estimulo, estimulo_valido, respuesta,
    input  ocupado, completo, contador_vectores, contador_errores, hubo_error, primer_error
  );

  modport slave (
    input  inicio, estimulo, estimulo_valido, respuesta,
    output ocupado, completo, contador_vectores, contador_errores, hubo_error, primer_error
  );
endinterface

// File: rtl/verificador_xor.sv
// Response monitor for an XOR device: delays the expected value by LATENCIA, compares and keeps session statistics.
// Optional feature: VERIFICADOR_COBERTURA_EN ends the session on full value coverage instead of NUM_VECTORES.
module verificador_xor #(
  parameter int ANCHO        = 2,
  parameter int LATENCIA     = 0,
  parameter int NUM_VECTORES = 4
) (
  input  logic                clk,
  input  logic                reset,
  verificador_xor_if.slave    bus
);

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    CHEQUEO  = 2'd1,
    COMPLETO = 2'd2
  } estado_t;

  estado_t          estado_q;
  logic             ocupado_q;
  logic             completo_q;
  logic [15:0]      contador_vectores_q;
  logic [15:0]      contador_vectores_d;
  logic [7:0]       contador_errores_q;
  logic [7:0]       contador_errores_d;
  logic             hubo_error_q;
  logic             hubo_error_d;
  logic [ANCHO-1:0] primer_error_q;
  logic [ANCHO-1:0] primer_error_d;

  logic             entrada_valida;
  logic             d_valido;
  logic             d_esperado;
  logic [ANCHO-1:0] d_estimulo;
  logic             compara;
  logic             discrepancia;
  logic             fin_cond;
  logic             fin;
  logic             vaciar;

  // Only stimuli seen while a session is running may enter the delay line.
  assign entrada_valida = bus.estimulo_valido && (estado_q == CHEQUEO);

  generate
    if (LATENCIA == 0) begin : g_sin_retardo
      assign d_valido   = entrada_valida;
      assign d_esperado = ^bus.estimulo;
      assign d_estimulo = bus.estimulo;
    end else begin : g_retardo
      logic [LATENCIA-1:0] val_q;
      logic [LATENCIA-1:0] esp_q;
      logic [ANCHO-1:0]    est_q [LATENCIA];

      always_ff @(posedge clk) begin
        if (reset || vaciar) begin
          for (int i = 0; i < LATENCIA; i++) begin
            val_q[i] <= 1'b0;
            esp_q[i] <= 1'b0;
            est_q[i] <= '0;
          end
        end else begin
          val_q[0] <= entrada_valida;
          esp_q[0] <= ^bus.estimulo;
          est_q[0] <= bus.estimulo;
          for (int i = 1; i < LATENCIA; i++) begin
            val_q[i] <= val_q[i-1];
            esp_q[i] <= esp_q[i-1];
            est_q[i] <= est_q[i-1];
          end
        end
      end

      assign d_valido   = val_q[LATENCIA-1];
      assign d_esperado = esp_q[LATENCIA-1];
      assign d_estimulo = est_q[LATENCIA-1];
    end
  endgenerate

  // A restart in the same cycle drops the compare that would otherwise happen.
  assign compara      = d_valido && (estado_q == CHEQUEO) && !bus.inicio;
  assign discrepancia = bus.respuesta ^ d_esperado;
  assign contador_vectores_d = contador_vectores_q + 16'd1;

`ifdef VERIFICADOR_COBERTURA_EN
  localparam int NCOV = 1 << ANCHO;
  logic [NCOV-1:0] cobertura_q;
  logic [NCOV-1:0] cobertura_d;

  assign cobertura_d = cobertura_q | (NCOV'(1) << d_estimulo);
  assign fin_cond    = &cobertura_d;

  always_ff @(posedge clk) begin
    if (reset || bus.inicio) begin
      cobertura_q <= '0;
    end else if (compara) begin
      cobertura_q <= cobertura_d;
    end
  end
`else
  assign fin_cond = (contador_vectores_d == 16'(NUM_VECTORES));
`endif

  assign fin    = compara && fin_cond;
  assign vaciar = bus.inicio || fin;

  always_comb begin
    contador_errores_d = contador_errores_q;
    hubo_error_d       = hubo_error_q;
    primer_error_d     = primer_error_q;
    if (discrepancia) begin
      if (contador_errores_q != 8'hFF) begin
        contador_errores_d = contador_errores_q + 8'd1;
      end
      hubo_error_d = 1'b1;
      if (!hubo_error_q) begin
        primer_error_d = d_estimulo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q            <= ESPERA;
      ocupado_q           <= 1'b0;
      completo_q          <= 1'b0;
      contador_vectores_q <= '0;
      contador_errores_q  <= '0;
      hubo_error_q        <= 1'b0;
      primer_error_q      <= '0;
    end else if (bus.inicio) begin
      estado_q            <= CHEQUEO;
      ocupado_q           <= 1'b1;
      completo_q          <= 1'b0;
      contador_vectores_q <= '0;
      contador_errores_q  <= '0;
      hubo_error_q        <= 1'b0;
      primer_error_q      <= '0;
    end else if (compara) begin
      contador_vectores_q <= contador_vectores_d;
      contador_errores_q  <= contador_errores_d;
      hubo_error_q        <= hubo_error_d;
      primer_error_q      <= primer_error_d;
      if (fin_cond) begin
        estado_q   <= COMPLETO;
        ocupado_q  <= 1'b0;
        completo_q <= 1'b1;
      end
    end
  end

  assign bus.ocupado           = ocupado_q;
  assign bus.completo          = completo_q;
  assign bus.contador_vectores = contador_vectores_q;
  assign bus.contador_errores  = contador_errores_q;
  assign bus.hubo_error        = hubo_error_q;
  assign bus.primer_error      = primer_error_q;

endmodule

// File: tb/tb_verificador_xor.sv
// Bench for verificador_xor: two monitors (latency 0 / 4 vectors, latency 2 / 300 vectors) share one stimulus stream.
// A history-based model predicts every output each cycle; literal checks pin the test-plan results.
module tb_verificador_xor;

  logic       clk;
  logic       rst;
  logic       ini;
  logic       val;
  logic       inv;
  logic [1:0] est;
  logic [1:0] est_d1, est_d2;
  logic       inv_d1, inv_d2;
  logic       resp_a, resp_b;

  int checks;
  int errors;

  verificador_xor_if #(.ANCHO(2)) bus_a ();
  verificador_xor_if #(.ANCHO(2)) bus_b ();

  verificador_xor #(.ANCHO(2), .LATENCIA(0), .NUM_VECTORES(4)) dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_a)
  );

  verificador_xor #(.ANCHO(2), .LATENCIA(2), .NUM_VECTORES(300)) dut_b (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_b)
  );

  // Ideal XOR device, optionally inverted; B's copy answers two cycles late.
  assign resp_a = (^est) ^ inv;
  assign resp_b = (^est_d2) ^ inv_d2;

  assign bus_a.inicio = ini;
  assign bus_a.estimulo = est;
  assign bus_a.estimulo_valido = val;
  assign bus_a.respuesta = resp_a;
  assign bus_b.inicio = ini;
  assign bus_b.estimulo = est;
  assign bus_b.estimulo_valido = val;
  assign bus_b.respuesta = resp_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    est_d1 <= est;
    est_d2 <= est_d1;
    inv_d1 <= inv;
    inv_d2 <= inv_d1;
  end

  // Model: per-cycle acceptance history plus the cycle of the last pipeline flush.
  int         lat_k [2] = '{0, 2};
  int         num_k [2] = '{4, 300};
  bit         acc  [2][4096];
  logic [1:0] hest [2][4096];
  int         flast [2];
  int         mst  [2];
  int         mvec [2];
  int         merr [2];
  bit         mhubo [2];
  int         mprim [2];
  bit [3:0]   seen [2];
  int         cyc;
  bit         armed;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input int k, input bit r);
    int  s;
    bit  cmp;
    bit  done;
    s = cyc - lat_k[k];
    if (rst) begin
      mst[k] = 0; mvec[k] = 0; merr[k] = 0; mhubo[k] = 0; mprim[k] = 0;
      seen[k] = '0; flast[k] = cyc; acc[k][cyc & 4095] = 0;
      return;
    end
    acc[k][cyc & 4095]  = val && (mst[k] == 1);
    hest[k][cyc & 4095] = est;
    cmp = (s >= 0) && (mst[k] == 1) && !ini && acc[k][s & 4095] && (flast[k] < s || lat_k[k] == 0);
    if (ini) begin
      mst[k] = 1; mvec[k] = 0; merr[k] = 0; mhubo[k] = 0; mprim[k] = 0;
      seen[k] = '0; flast[k] = cyc;
    end else if (cmp) begin
      mvec[k] = (mvec[k] + 1) % 65536;
      if (r != ^hest[k][s & 4095]) begin
        if (merr[k] < 255) merr[k]++;
        if (!mhubo[k]) begin
          mhubo[k] = 1;
          mprim[k] = int'(hest[k][s & 4095]);
        end
      end
      seen[k][hest[k][s & 4095]] = 1'b1;
`ifdef VERIFICADOR_COBERTURA_EN
      done = (seen[k] == 4'hF);
`else
      done = (mvec[k] == num_k[k]);
`endif
      if (done) begin
        mst[k] = 2;
        flast[k] = cyc;
      end
    end
  endtask

  task automatic compare_one(input string tag, input int k, input int oc, input int co,
                             input int vec, input int er, input int hu, input int pr);
    check({tag, ".ocupado"}, oc, int'(mst[k] == 1));
    check({tag, ".completo"}, co, int'(mst[k] == 2));
    check({tag, ".contador_vectores"}, vec, mvec[k]);
    check({tag, ".contador_errores"}, er, merr[k]);
    check({tag, ".hubo_error"}, hu, int'(mhubo[k]));
    check({tag, ".primer_error"}, pr, mprim[k]);
  endtask

  task automatic tick();
    @(negedge clk);
    if (armed) begin
      compare_one("A", 0, int'(bus_a.ocupado), int'(bus_a.completo), int'(bus_a.contador_vectores),
                  int'(bus_a.contador_errores), int'(bus_a.hubo_error), int'(bus_a.primer_error));
      compare_one("B", 1, int'(bus_b.ocupado), int'(bus_b.completo), int'(bus_b.contador_vectores),
                  int'(bus_b.contador_errores), int'(bus_b.hubo_error), int'(bus_b.primer_error));
    end
    model_step(0, resp_a);
    model_step(1, resp_b);
    if (rst) armed = 1'b1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] e, input bit bad);
    est = e;
    val = 1'b1;
    inv = bad;
    $display("tx cycle=%0d est=%b inverted=%0d inicio=%0d", cyc, e, bad, ini);
    tick();
    val = 1'b0;
    inv = 1'b0;
    est = 2'b00;
  endtask

  task automatic pulse_inicio();
    ini = 1'b1;
    tick();
    ini = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; armed = 1'b0;
    rst = 1'b1; ini = 1'b0; val = 1'b0; inv = 1'b0; est = 2'b00;
    for (int k = 0; k < 2; k++) begin
      flast[k] = -100; mst[k] = 0; mvec[k] = 0; merr[k] = 0; mhubo[k] = 0; mprim[k] = 0; seen[k] = '0;
    end
    @(posedge clk); #1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset.ocupado", int'(bus_a.ocupado), 0);
    check("reset.completo", int'(bus_b.completo), 0);
    check("reset.vectores", int'(bus_a.contador_vectores), 0);
    check("reset.primer", int'(bus_b.primer_error), 0);

    // Correct responses
    pulse_inicio();
    check("t1.ocupado_tras_inicio", int'(bus_a.ocupado), 1);
    send(2'b00, 0); send(2'b01, 0); send(2'b10, 0);
    check("t1.completo_antes", int'(bus_a.completo), 0);
    send(2'b11, 0);
    check("t1.completo", int'(bus_a.completo), 1);
    check("t1.ocupado", int'(bus_a.ocupado), 0);
    check("t1.vectores", int'(bus_a.contador_vectores), 4);
    check("t1.errores", int'(bus_a.contador_errores), 0);
    check("t1.hubo", int'(bus_a.hubo_error), 0);
    idle(3);
    check("t1.B_vectores", int'(bus_b.contador_vectores), 4);
    check("t1.B_errores", int'(bus_b.contador_errores), 0);

    // Single fault on vector 10
    pulse_inicio();
    send(2'b00, 0); send(2'b01, 0); send(2'b10, 1); send(2'b11, 0);
    check("t2.errores", int'(bus_a.contador_errores), 1);
    check("t2.hubo", int'(bus_a.hubo_error), 1);
    check("t2.primer", int'(bus_a.primer_error), 2);
    check("t2.completo", int'(bus_a.completo), 1);
    idle(3);

    // Latency 2 with back-to-back stimuli, all responses inverted (saturation on B)
    pulse_inicio();
    for (int i = 0; i < 300; i++) begin
      send(2'((i + 1) % 4), 1);
      if (i == 0) check("lat.vec_S", int'(bus_b.contador_vectores), 0);
      if (i == 1) check("lat.vec_S1", int'(bus_b.contador_vectores), 0);
      if (i == 2) check("lat.vec_S2", int'(bus_b.contador_vectores), 1);
      if (i == 3) check("lat.vec_S3", int'(bus_b.contador_vectores), 2);
    end
    idle(3);
    check("sat.A_errores", int'(bus_a.contador_errores), 4);
    check("sat.A_primer", int'(bus_a.primer_error), 1);
`ifndef VERIFICADOR_COBERTURA_EN
    check("sat.B_errores", int'(bus_b.contador_errores), 255);
    check("sat.B_vectores", int'(bus_b.contador_vectores), 300);
    check("sat.B_primer", int'(bus_b.primer_error), 1);
    check("sat.B_completo", int'(bus_b.completo), 1);
`endif

    // Repeated value, then the remaining three
    pulse_inicio();
    for (int i = 0; i < 10; i++) send(2'b00, 0);
`ifdef VERIFICADOR_COBERTURA_EN
    check("cov.completo_10", int'(bus_a.completo), 0);
    check("cov.vectores_10", int'(bus_a.contador_vectores), 10);
`else
    check("cov.completo_10", int'(bus_a.completo), 1);
    check("cov.vectores_10", int'(bus_a.contador_vectores), 4);
`endif
    send(2'b01, 0); send(2'b10, 0);
`ifdef VERIFICADOR_COBERTURA_EN
    check("cov.completo_12", int'(bus_a.completo), 0);
`endif
    send(2'b11, 0);
    check("cov.completo_13", int'(bus_a.completo), 1);
`ifdef VERIFICADOR_COBERTURA_EN
    check("cov.vectores_13", int'(bus_a.contador_vectores), 13);
`else
    check("cov.vectores_13", int'(bus_a.contador_vectores), 4);
`endif
    idle(3);

    // Reset mid-session, then restart
    pulse_inicio();
    send(2'b01, 1); send(2'b10, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst.A_ocupado", int'(bus_a.ocupado), 0);
    check("rst.A_vectores", int'(bus_a.contador_vectores), 0);
    check("rst.A_errores", int'(bus_a.contador_errores), 0);
    check("rst.A_hubo", int'(bus_a.hubo_error), 0);
    check("rst.A_primer", int'(bus_a.primer_error), 0);
    check("rst.B_vectores", int'(bus_b.contador_vectores), 0);
    idle(2);
    check("rst.B_tras_pipeline", int'(bus_b.contador_vectores), 0);
    pulse_inicio();
    send(2'b00, 0); send(2'b01, 0); send(2'b10, 0); send(2'b11, 0);
    check("restart.vectores", int'(bus_a.contador_vectores), 4);
    check("restart.completo", int'(bus_a.completo), 1);

    // inicio from COMPLETO
    pulse_inicio();
    check("recomp.ocupado", int'(bus_a.ocupado), 1);
    check("recomp.completo", int'(bus_a.completo), 0);
    check("recomp.vectores", int'(bus_a.contador_vectores), 0);

    // inicio coinciding with a compare drops it
    send(2'b01, 1); send(2'b10, 0); send(2'b11, 1);
    ini = 1'b1;
    send(2'b01, 0);
    ini = 1'b0;
    check("coinc.A_vectores", int'(bus_a.contador_vectores), 0);
    check("coinc.A_hubo", int'(bus_a.hubo_error), 0);
    check("coinc.A_ocupado", int'(bus_a.ocupado), 1);
    idle(4);
    check("coinc.B_vectores", int'(bus_b.contador_vectores), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
